// File: rtl/tank_gfx_pkg.sv
// Shared graphics types for the tank tile engine: tile codes, atlas placement, default map.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package tank_gfx_pkg;

    typedef enum logic [1:0] {
        ROAD  = 2'd0,
        WALL  = 2'd1,
        BRICK = 2'd2,
        WATER = 2'd3
    } tile_type_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_t;

    // Texel value that means "let the layer underneath show through".
    localparam logic [11:0] TRANSPARENT = 12'h00F;

    typedef struct packed {
        logic [2:0] col;
        logic [2:0] row;
    } atlas_pos_t;

    // Where each tile type's artwork lives in the atlas, in tile units.
    function automatic atlas_pos_t atlas_pos(input tile_type_t t);
        atlas_pos_t p;
        case (t)
            ROAD:    p = '{col: 3'd7, row: 3'd1};
            WALL:    p = '{col: 3'd0, row: 3'd0};
            BRICK:   p = '{col: 3'd1, row: 3'd0};
            WATER:   p = '{col: 3'd2, row: 3'd0};
            default: p = '{col: 3'd0, row: 3'd0};
        endcase
        return p;
    endfunction

    // Default 16x16 arena: walled border, two brick/water fortification rows.
    // Element [0] of each dimension is listed first (row 0 / column 0).
    typedef logic [0:15][1:0] map_row_t;

    localparam map_row_t ROW_EDGE = {16{2'd1}};
    localparam map_row_t ROW_OPEN = {2'd1, {14{2'd0}}, 2'd1};
    localparam map_row_t ROW_FORT = {2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0,
                                     2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};

    localparam logic [0:15][0:15][1:0] DEFAULT_MAP = {
        ROW_EDGE, ROW_OPEN, ROW_OPEN, ROW_OPEN,
        ROW_FORT, ROW_OPEN, ROW_OPEN, ROW_OPEN,
        ROW_OPEN, ROW_OPEN, ROW_OPEN, ROW_FORT,
        ROW_OPEN, ROW_OPEN, ROW_OPEN, ROW_EDGE
    };

endpackage

// File: rtl/tile_atlas_rom.sv
// Tile artwork atlas ROM, procedurally generated texels.
// Latency: 1 cycle from address to texel (synchronous read).
// Backpressure: none; one lookup per cycle, always ready.
// Ports: clk; ax/ay atlas pixel coordinate in; texel RGB444 out.
module tile_atlas_rom (
    input  logic        clk,
    input  logic [9:0]  ax,
    input  logic [9:0]  ay,
    output logic [11:0] texel
);

    logic [11:0] texel_d;
    logic [11:0] texel_q;

    // R follows the coarse x position, G the coarse y position, B a local
    // checker pattern. The top address bits are folded into R/G so that
    // wide-tile atlases still get distinct art beyond 256 pixels.
    always_comb begin
        texel_d = {ax[7:4] ^ {2'b00, ax[9:8]},
                   ay[7:4] ^ {2'b00, ay[9:8]},
                   ax[3:0] ^ ay[3:0]};
    end

    always_ff @(posedge clk) begin
        texel_q <= texel_d;
    end

    assign texel = texel_q;

endmodule

// File: rtl/tilemap_engine.sv
// Tile-map background renderer with tile RAM, update port, collision query and map loader.
// Latency: x/y/video_on -> color/pixel_on 3 cycles fixed; query 1 cycle; wr_err 1 cycle after accept.
// Backpressure: wr_ready low only while the default map is being loaded (busy); render never stalls.
// Ports: clk/reset; video_on,x,y scan in; pixel_on,color out; wr_* update handshake + wr_err;
//        q_col/q_row -> q_type collision query; init_req reload request, busy while loading.
module tilemap_engine
    import tank_gfx_pkg::*;
#(
    parameter int TILE_W   = 32,
    parameter int TILE_H   = 32,
    parameter int MAP_COLS = 16,
    parameter int MAP_ROWS = 16,
    parameter int TYPE_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic              pixel_on,
    output logic [11:0]       color,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4:0]        wr_col,
    input  logic [4:0]        wr_row,
    input  logic [TYPE_W-1:0] wr_type,
    output logic              wr_err,
    input  logic [4:0]        q_col,
    input  logic [4:0]        q_row,
    output logic [TYPE_W-1:0] q_type,
    input  logic              init_req,
    output logic              busy
);

    localparam int CELLS  = MAP_COLS * MAP_ROWS;
    localparam int IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int XOFF_W = $clog2(TILE_W);
    localparam int YOFF_W = $clog2(TILE_H);

    function automatic logic [IDX_W-1:0] cell_idx(input logic [4:0] row, input logic [4:0] col);
        return IDX_W'(int'(row) * MAP_COLS + int'(col));
    endfunction

    // ---------------- tile RAM ----------------
    logic [TYPE_W-1:0] tile_ram_q [CELLS];
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [TYPE_W-1:0] ram_wdat;

    // Reads elsewhere are combinational from this array and registered,
    // so a same-cycle write is seen by readers only on the following cycle.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            tile_ram_q[ram_waddr] <= ram_wdat;
        end
    end

    // ---------------- state ----------------
    fsm_state_t        state_q, state_d;
    logic [4:0]        init_col_q, init_col_d;
    logic [4:0]        init_row_q, init_row_d;
    logic              busy_q, busy_d;
    logic              wr_ready_q, wr_ready_d;
    logic              wr_err_q, wr_err_d;
    logic [TYPE_W-1:0] q_type_q, q_type_d;

    // render pipeline
    logic              s1_vld_q, s1_vld_d;
    logic              s1_inmap_q, s1_inmap_d;
    logic [4:0]        s1_col_q, s1_col_d;
    logic [4:0]        s1_row_q, s1_row_d;
    logic [XOFF_W-1:0] s1_xoff_q, s1_xoff_d;
    logic [YOFF_W-1:0] s1_yoff_q, s1_yoff_d;
    logic              s2_vld_q, s2_vld_d;
    logic              s2_inmap_q, s2_inmap_d;
    logic [9:0]        s2_ax_q, s2_ax_d;
    logic [9:0]        s2_ay_q, s2_ay_d;
    logic              s3_vld_q, s3_vld_d;
    logic              s3_inmap_q, s3_inmap_d;

    logic              wr_fire;
    logic              wr_in_range;
    logic              q_in_range;
    logic [TYPE_W-1:0] s2_type;
    tile_type_t        s2_tile;
    atlas_pos_t        s2_atl;
    logic [11:0]       rom_texel;

    // ---------------- control / write path ----------------
    always_comb begin
        state_d    = state_q;
        init_col_d = init_col_q;
        init_row_d = init_row_q;
        busy_d     = busy_q;
        wr_ready_d = wr_ready_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdat   = '0;

        wr_fire     = wr_valid && wr_ready_q;
        wr_in_range = (int'(wr_col) < MAP_COLS) && (int'(wr_row) < MAP_ROWS);
        // Out-of-range writes are still consumed; they only raise an error.
        wr_err_d    = wr_fire && !wr_in_range;

        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cell_idx(init_row_q, init_col_q);
                ram_wdat  = TYPE_W'(DEFAULT_MAP[init_row_q[3:0]][init_col_q[3:0]]);
                if (init_col_q == 5'(MAP_COLS - 1)) begin
                    init_col_d = '0;
                    if (init_row_q == 5'(MAP_ROWS - 1)) begin
                        init_row_d = '0;
                        state_d    = ST_RUN;
                        busy_d     = 1'b0;
                        wr_ready_d = 1'b1;
                    end else begin
                        init_row_d = init_row_q + 5'd1;
                    end
                end else begin
                    init_col_d = init_col_q + 5'd1;
                end
            end
            default: begin
                if (wr_fire && wr_in_range) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_idx(wr_row, wr_col);
                    ram_wdat  = wr_type;
                end
                if (init_req) begin
                    state_d    = ST_INIT;
                    init_col_d = '0;
                    init_row_d = '0;
                    busy_d     = 1'b1;
                    wr_ready_d = 1'b0;
                end
            end
        endcase

        // No RAM update while reset is held, so an interrupted load or write leaves nothing half-done.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // ---------------- collision query ----------------
    always_comb begin
        q_in_range = (int'(q_col) < MAP_COLS) && (int'(q_row) < MAP_ROWS);
        q_type_d   = q_in_range ? tile_ram_q[cell_idx(q_row, q_col)] : TYPE_W'(WALL);
    end

    // ---------------- render pipeline ----------------
    always_comb begin
        // S1: split scan position into tile coordinate and in-tile offset.
        s1_vld_d   = video_on;
        s1_inmap_d = (int'(x >> XOFF_W) < MAP_COLS) && (int'(y >> YOFF_W) < MAP_ROWS);
        s1_col_d   = 5'(x >> XOFF_W);
        s1_row_d   = 5'(y >> YOFF_W);
        s1_xoff_d  = x[XOFF_W-1:0];
        s1_yoff_d  = y[YOFF_W-1:0];

        // S2: tile lookup and atlas placement. Codes beyond the named types render as wall art.
        s2_type    = tile_ram_q[cell_idx(s1_row_q, s1_col_q)];
        s2_tile    = (int'(s2_type) < 4) ? tile_type_t'(s2_type[1:0]) : WALL;
        s2_atl     = atlas_pos(s2_tile);
        s2_vld_d   = s1_vld_q;
        s2_inmap_d = s1_inmap_q;
        // Tile sizes are powers of two, so col*TILE_W + offset is a concatenation.
        s2_ax_d    = 10'({s2_atl.col, s1_xoff_q});
        s2_ay_d    = 10'({s2_atl.row, s1_yoff_q});

        // S3 flags travel alongside the ROM's own output register.
        s3_vld_d   = s2_vld_q;
        s3_inmap_d = s2_inmap_q;
    end

    tile_atlas_rom u_atlas (
        .clk   (clk),
        .ax    (s2_ax_q),
        .ay    (s2_ay_q),
        .texel (rom_texel)
    );

    always_comb begin
        pixel_on = s3_vld_q && s3_inmap_q && (state_q == ST_RUN) && (rom_texel != TRANSPARENT);
        color    = pixel_on ? rom_texel : 12'h000;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_col_q <= '0;
            init_row_q <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            q_type_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_inmap_q <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_xoff_q  <= '0;
            s1_yoff_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_inmap_q <= 1'b0;
            s2_ax_q    <= '0;
            s2_ay_q    <= '0;
            s3_vld_q   <= 1'b0;
            s3_inmap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_col_q <= init_col_d;
            init_row_q <= init_row_d;
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
            wr_err_q   <= wr_err_d;
            q_type_q   <= q_type_d;
            s1_vld_q   <= s1_vld_d;
            s1_inmap_q <= s1_inmap_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            s1_xoff_q  <= s1_xoff_d;
            s1_yoff_q  <= s1_yoff_d;
            s2_vld_q   <= s2_vld_d;
            s2_inmap_q <= s2_inmap_d;
            s2_ax_q    <= s2_ax_d;
            s2_ay_q    <= s2_ay_d;
            s3_vld_q   <= s3_vld_d;
            s3_inmap_q <= s3_inmap_d;
        end
    end

    assign busy     = busy_q;
    assign wr_ready = wr_ready_q;
    assign wr_err   = wr_err_q;
    assign q_type   = q_type_q;

endmodule

// File: tb/tb_tilemap_engine.sv
// Directed bench for tilemap_engine with hand-computed texels and map contents.
// Latency: checks render 3 cycles after inputs, queries 1 cycle after address.
// Backpressure: exercises wr_ready low during map loading and reset mid-load.
module tb_tilemap_engine;

    logic        clk;
    logic        reset;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pixel_on;
    logic [11:0] color;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_col;
    logic [4:0]  wr_row;
    logic [1:0]  wr_type;
    logic        wr_err;
    logic [4:0]  q_col;
    logic [4:0]  q_row;
    logic [1:0]  q_type;
    logic        init_req;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cnt;

    tilemap_engine #(
        .TILE_W(32), .TILE_H(32), .MAP_COLS(16), .MAP_ROWS(16), .TYPE_W(2)
    ) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
        .pixel_on(pixel_on), .color(color),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
        .wr_type(wr_type), .wr_err(wr_err),
        .q_col(q_col), .q_row(q_row), .q_type(q_type),
        .init_req(init_req), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1ns after the edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic render(input int px, input int py, input logic von);
        x = 10'(px);
        y = 10'(py);
        video_on = von;
        repeat (3) step();
    endtask

    task automatic query(input int c, input int r);
        q_col = 5'(c);
        q_row = 5'(r);
        step();
    endtask

    // Independent description of the default arena.
    function automatic logic [1:0] exp_map(input int r, input int c);
        if (r == 0 || r == 15 || c == 0 || c == 15) return 2'd1;
        if ((r == 4 || r == 11) && c >= 3 && c <= 5) return 2'd2;
        if ((r == 4 || r == 11) && (c == 10 || c == 11)) return 2'd3;
        return 2'd0;
    endfunction

    task automatic readback(input string pfx, input int mr, input int mc, input logic [1:0] mt);
        logic [1:0] e;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                query(c, r);
                e = (r == mr && c == mc) ? mt : exp_map(r, c);
                check($sformatf("%s r%0d c%0d", pfx, r, c), 32'(q_type), 32'(e));
            end
        end
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b0; x = '0; y = '0;
        wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_type = '0;
        q_col = '0; q_row = '0; init_req = 1'b0;

        // ---- reset state ----
        repeat (2) step();
        check("rst pixel_on", 32'(pixel_on), 0);
        check("rst color",    32'(color),    0);
        check("rst wr_ready", 32'(wr_ready), 0);
        check("rst wr_err",   32'(wr_err),   0);
        check("rst q_type",   32'(q_type),   0);
        check("rst busy",     32'(busy),     1);
        reset = 1'b0;

        // ---- initial load lasts exactly 256 cycles ----
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            cnt++;
            if (!busy) break;
        end
        check("init busy cycles", 32'(cnt), 256);
        check("init wr_ready",    32'(wr_ready), 1);

        // ---- queries ----
        query(0, 0);   check("q(0,0) wall",   32'(q_type), 1);
        query(1, 1);   check("q(1,1) road",   32'(q_type), 0);
        query(10, 4);  check("q(10,4) water", 32'(q_type), 3);
        query(4, 11);  check("q(4,11) brick", 32'(q_type), 2);
        query(20, 0);  check("q(20,0) oor",   32'(q_type), 1);
        query(3, 16);  check("q(3,16) oor",   32'(q_type), 1);

        // ---- rendering ----
        render(40, 40, 1'b1);
        check("road color", 32'(color), 32'h0E20);
        check("road on",    32'(pixel_on), 1);
        render(20, 3, 1'b1);
        check("wall color", 32'(color), 32'h0107);
        check("wall on",    32'(pixel_on), 1);
        render(325, 134, 1'b1);
        check("water color", 32'(color), 32'h0403);
        check("water on",    32'(pixel_on), 1);
        render(15, 0, 1'b1);
        check("transp color", 32'(color), 0);
        check("transp on",    32'(pixel_on), 0);
        render(600, 40, 1'b1);
        check("x600 color", 32'(color), 0);
        check("x600 on",    32'(pixel_on), 0);
        render(40, 40, 1'b0);
        check("vid off color", 32'(color), 0);
        check("vid off on",    32'(pixel_on), 0);

        // ---- write colliding with render/query of the same cell ----
        render(40, 40, 1'b1);
        check("pre-wr color", 32'(color), 32'h0E20);
        wr_valid = 1'b1; wr_col = 5'd1; wr_row = 5'd1; wr_type = 2'd2;
        q_col = 5'd1; q_row = 5'd1;
        step();
        wr_valid = 1'b0;
        check("coll q old",  32'(q_type), 0);
        check("coll wr_err", 32'(wr_err), 0);
        step();
        check("coll color old", 32'(color), 32'h0E20);
        check("coll q new",     32'(q_type), 2);
        step();
        check("brick color", 32'(color), 32'h0200);
        check("brick on",    32'(pixel_on), 1);

        // ---- out-of-range writes ----
        wr_valid = 1'b1; wr_col = 5'd20; wr_row = 5'd1; wr_type = 2'd3;
        step();
        wr_valid = 1'b0;
        check("oor col err",  32'(wr_err), 1);
        step();
        check("oor col err clr", 32'(wr_err), 0);
        wr_valid = 1'b1; wr_col = 5'd0; wr_row = 5'd16; wr_type = 2'd3;
        step();
        wr_valid = 1'b0;
        check("oor row err",  32'(wr_err), 1);
        step();
        check("oor row err clr", 32'(wr_err), 0);
        check("oor wr_ready",    32'(wr_ready), 1);
        readback("rb1", 1, 1, 2'd2);

        // ---- reload interrupted by reset ----
        wr_valid = 1'b1; wr_col = 5'd4; wr_row = 5'd12; wr_type = 2'd3;
        step();
        wr_valid = 1'b0;
        query(4, 12);
        check("q(4,12) written", 32'(q_type), 3);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("reload busy",     32'(busy), 1);
        check("reload wr_ready", 32'(wr_ready), 0);
        check("reload pixel_on", 32'(pixel_on), 0);
        wr_valid = 1'b1; wr_col = 5'd1; wr_row = 5'd1; wr_type = 2'd3;
        for (int i = 0; i < 100; i++) begin
            step();
            check($sformatf("reload rdy c%0d", i + 1), 32'(wr_ready), 0);
        end
        reset = 1'b1;
        #1;
        check("mid rst busy",     32'(busy), 1);
        check("mid rst wr_ready", 32'(wr_ready), 0);
        check("mid rst q_type",   32'(q_type), 0);
        check("mid rst pixel_on", 32'(pixel_on), 0);
        check("mid rst color",    32'(color), 0);
        step();
        reset = 1'b0;

        // Load restarts from cell 0; a request mid-load must not restart it again.
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            cnt++;
            init_req = (cnt == 50);
            if (!busy) break;
            check($sformatf("restart rdy c%0d", cnt), 32'(wr_ready), 0);
        end
        wr_valid = 1'b0;
        init_req = 1'b0;
        check("restart busy cycles", 32'(cnt), 256);
        check("restart wr_ready",    32'(wr_ready), 1);
        readback("rb2", -1, -1, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tilemap_engine.md
TILEMAP_ENGINE -- requirements
Module: tilemap_engine

Interface
REQ-001 SHALL have parameter TILE_W, default 32, meaning tile width in pixels (power of two, 8..64).
REQ-002 SHALL have parameter TILE_H, default 32, meaning tile height in pixels (power of two, 8..64).
REQ-003 SHALL have parameter MAP_COLS, default 16, meaning map width in tiles (1..32).
REQ-004 SHALL have parameter MAP_ROWS, default 16, meaning map height in tiles (1..32).
REQ-005 SHALL have parameter TYPE_W, default 2, meaning tile-type code width (up to 2**TYPE_W types).
REQ-006 SHALL have ports clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-007 SHALL have ports video_on in 1; x in 10; y in 10, the current scan pixel.
REQ-008 SHALL have ports pixel_on out 1, non-transparent background pixel; color out 12, RGB444 pixel.
REQ-009 SHALL have ports wr_valid in 1; wr_ready out 1; wr_col in 5; wr_row in 5; wr_type in TYPE_W, the tile-update handshake.
REQ-010 SHALL have port wr_err out 1, one-cycle pulse for a rejected out-of-range write.
REQ-011 SHALL have ports q_col in 5; q_row in 5; q_type out TYPE_W, the collision query.
REQ-012 SHALL have ports init_req in 1, reload the default map; busy out 1, high during INIT.

Function
REQ-013 SHALL hold a MAP_COLS x MAP_ROWS tile RAM of TYPE_W-bit entries, three read ports (render, query, init) and one write port.
REQ-014 SHALL implement FSM states INIT and RUN; reset and init_req in RUN enter INIT; INIT exits to RUN after the last cell is written.
REQ-015 INIT SHALL write the default map in row-major order, one cell per cycle, MAP_COLS*MAP_ROWS cycles, busy=1 and wr_ready=0 throughout.
REQ-016 init_req SHALL be ignored while in INIT.
REQ-017 wr_ready SHALL be 1 in RUN and 0 in INIT; a write completes on the cycle wr_valid and wr_ready are both 1.
REQ-018 A write with wr_col>=MAP_COLS or wr_row>=MAP_ROWS SHALL be accepted, SHALL leave the RAM unchanged, and SHALL pulse wr_err on the next cycle.
REQ-019 Rendering SHALL be a 3-stage pipeline: S1 registers tile col=x/TILE_W, row=y/TILE_H, offsets, and video_on; S2 reads the tile type and maps it to atlas (col,row); S3 reads the atlas ROM and registers color/pixel_on.
REQ-020 Latency from x/y/video_on to color/pixel_on SHALL be exactly 3 cycles, fixed and independent of writes or FSM state.
REQ-021 Atlas address SHALL be atlas_col*TILE_W + x mod TILE_W, and atlas_row*TILE_H + y mod TILE_H.
REQ-022 pixel_on SHALL be 0 and color SHALL be 12'h000 when the delayed video_on is 0, x/y is outside the map extent, the ROM texel equals TRANSPARENT (12'h00F), or the FSM is in INIT.
REQ-023 Otherwise color SHALL be the ROM texel and pixel_on SHALL be 1.
REQ-024 A write and a render read of the same cell in the same cycle SHALL return the old value (read-first); the new value is visible from the next cycle.
REQ-025 q_type SHALL be registered, 1-cycle latency, with the same read-first rule; an out-of-range query SHALL return WALL.

Reset
REQ-026 On reset assertion: pixel_on=0, color=0, wr_ready=0, wr_err=0, q_type=0, busy=1, pipeline valid bits cleared, FSM=INIT at cell 0.
REQ-027 Reset asserted mid-INIT or mid-write SHALL abort the operation; after release INIT SHALL restart from cell 0.

Structure
REQ-028 Package tank_gfx_pkg SHALL hold the tile_type_t enum (ROAD=0, WALL=1, BRICK=2, WATER=3), TRANSPARENT, the per-type atlas (col,row) table, and the default 16x16 map constant.
REQ-029 The atlas ROM SHALL be the sub-module tile_atlas_rom, synchronous read, 1-cycle latency; the tile RAM and FSM SHALL stay in tilemap_engine.

Verification
REQ-030 Reset, then count cycles: busy=1 for exactly 256 cycles, then busy=0 and wr_ready=1; q(0,0) returns WALL and q(1,1) returns ROAD.
REQ-031 Drive x=40, y=40 (road cell 1,1), video_on=1: 3 cycles later color equals the ROAD atlas texel at (7*32+8, 1*32+8), and pixel_on=1.
REQ-032 Write (col 1, row 1, BRICK), then render x=40, y=40: the BRICK texel appears 3 cycles after the next scan of that pixel; in the same-cycle collision case the old ROAD texel is returned.
REQ-033 Write to col 20 or row 16: wr_err=1 for one cycle, and a full RAM readback is unchanged.
REQ-034 Render x=600, then video_on=0, then a transparent texel: pixel_on=0 and color=0 3 cycles later in each case.
REQ-035 Assert init_req after a write, then assert reset at INIT cell 100: INIT restarts at 0, the map returns to default, and wr_valid during INIT is never accepted.
